// File: rtl/minirisc_store_fifo.sv
// minirisc_store_fifo: captures the core accumulator each time the core enters
// its STORE state and buffers it in a small first-word-fall-through FIFO.
//
// Optional feature macro: MINIRISC_STORE_STAMP_EN
//   defined   : every entry also carries an 8-bit cycle stamp (rd_stamp)
//   undefined : no stamp counter or stamp array; rd_stamp is tied to 0
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   ena                 capture enable (mirrors core ena)
//   acc_in[7:0]         core accumulator value
//   state_in[3:0]       core state nibble
//   clr                 synchronous flush
//   rd_data[7:0]        head entry (0 when empty)
//   rd_stamp[7:0]       head entry stamp (0 when empty / feature disabled)
//   rd_valid            FIFO non-empty
//   rd_ready            consumer accepts head entry
//   count[ADDR_W:0]     occupancy 0..DEPTH
//   full                count == DEPTH
//   overflow            sticky: a capture was dropped
module minirisc_store_fifo #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_W     = 3,
  parameter logic [3:0]  STORE_CODE = 4'h4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [7:0]        acc_in,
  input  logic [3:0]        state_in,
  input  logic              clr,
  output logic [7:0]        rd_data,
  output logic [7:0]        rd_stamp,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              overflow
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = ADDR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] rd_ptr, wr_ptr;
  logic [3:0]        prev_state;

  logic              cap_c, pop_c, push_c, wr_en_c;
  logic [ADDR_W-1:0] rd_ptr_nxt, wr_ptr_nxt;
  logic [CNT_W-1:0]  count_nxt;
  logic              ovf_nxt;
  logic [DATA_W-1:0] head_nxt;
  logic              head_is_new_c;

  // Entry-edge capture, pop/push qualification
  always_comb begin
    cap_c   = ena && (state_in == STORE_CODE) && (prev_state != STORE_CODE);
    pop_c   = rd_valid && rd_ready;
    push_c  = cap_c && (!full || pop_c);
    wr_en_c = push_c && !clr;
  end

  // Next-state for pointers, occupancy and overflow; clr wins over push/pop
  always_comb begin
    rd_ptr_nxt = rd_ptr;
    wr_ptr_nxt = wr_ptr;
    count_nxt  = count;
    ovf_nxt    = overflow;
    if (clr) begin
      rd_ptr_nxt = '0;
      wr_ptr_nxt = '0;
      count_nxt  = '0;
      ovf_nxt    = 1'b0;
    end else begin
      if (pop_c)  rd_ptr_nxt = rd_ptr + ADDR_W'(1);
      if (push_c) wr_ptr_nxt = wr_ptr + ADDR_W'(1);
      if (push_c && !pop_c)      count_nxt = count + CNT_W'(1);
      else if (pop_c && !push_c) count_nxt = count - CNT_W'(1);
      if (cap_c && full && !pop_c) ovf_nxt = 1'b1;
    end
  end

  // Head after this edge: bypass the incoming word when it lands in the head slot
  always_comb begin
    head_is_new_c = wr_en_c && (wr_ptr == rd_ptr_nxt);
    head_nxt      = head_is_new_c ? acc_in : mem[rd_ptr_nxt];
  end

  // Storage array (no reset; never visible while empty)
  always_ff @(posedge clk) begin
    if (wr_en_c) mem[wr_ptr] <= acc_in;
  end

  // Control state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      prev_state <= '0;
      full       <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
    end else begin
      rd_ptr     <= rd_ptr_nxt;
      wr_ptr     <= wr_ptr_nxt;
      count      <= count_nxt;
      overflow   <= ovf_nxt;
      prev_state <= state_in;
      full       <= (count_nxt == CNT_W'(DEPTH));
      rd_valid   <= (count_nxt != '0);
      rd_data    <= (count_nxt != '0) ? head_nxt : '0;
    end
  end

`ifdef MINIRISC_STORE_STAMP_EN
  logic [7:0] stamp_cnt;
  logic [7:0] stamp_mem [DEPTH];
  logic [7:0] stamp_head_nxt;

  always_comb begin
    stamp_head_nxt = head_is_new_c ? stamp_cnt : stamp_mem[rd_ptr_nxt];
  end

  always_ff @(posedge clk) begin
    if (wr_en_c) stamp_mem[wr_ptr] <= stamp_cnt;
  end

  // Free-running cycle counter (advances only while ena) and stamp output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stamp_cnt <= '0;
      rd_stamp  <= '0;
    end else begin
      if (clr)      stamp_cnt <= '0;
      else if (ena) stamp_cnt <= stamp_cnt + 8'(1);
      rd_stamp <= (count_nxt != '0) ? stamp_head_nxt : '0;
    end
  end
`else
  assign rd_stamp = 8'h00;
`endif

endmodule

// File: tb/tb_minirisc_store_fifo.sv
// Directed self-checking bench for minirisc_store_fifo (DEPTH=8).
module tb_minirisc_store_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] acc_in;
  logic [3:0] state_in;
  logic       clr;
  logic [7:0] rd_data;
  logic [7:0] rd_stamp;
  logic       rd_valid;
  logic       rd_ready;
  logic [3:0] count;
  logic       full;
  logic       overflow;

  int n_cmp = 0;
  int n_err = 0;

`ifdef MINIRISC_STORE_STAMP_EN
  localparam logic [7:0] STAMP_A = 8'd5;
  localparam logic [7:0] STAMP_B = 8'd12;
`else
  localparam logic [7:0] STAMP_A = 8'd0;
  localparam logic [7:0] STAMP_B = 8'd0;
`endif

  minirisc_store_fifo #(.DEPTH(8), .ADDR_W(3), .STORE_CODE(4'h4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .acc_in   (acc_in),
    .state_in (state_in),
    .clr      (clr),
    .rd_data  (rd_data),
    .rd_stamp (rd_stamp),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .count    (count),
    .full     (full),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge; outputs are sampled 1 time unit later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Enter STORE for one cycle with value v, then leave it
  task automatic capture(input logic [7:0] v);
    state_in = 4'h4;
    acc_in   = v;
    step();
    state_in = 4'h0;
    step();
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; acc_in = 8'h00; state_in = 4'h0;
    clr = 1'b0; rd_ready = 1'b0;
    step();
    step();
    chk("rst_valid",    32'(rd_valid), 32'd0);
    chk("rst_count",    32'(count),    32'd0);
    chk("rst_full",     32'(full),     32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_data",     32'(rd_data),  32'd0);
    chk("rst_stamp",    32'(rd_stamp), 32'd0);
    rst_n = 1'b1;

    // Stamp test: captures on the 6th and 13th edge after release (counter 5, 12)
    repeat (5) step();
    state_in = 4'h4; acc_in = 8'hA1;
    step();
    chk("stamp_a_valid", 32'(rd_valid), 32'd1);
    chk("stamp_a_data",  32'(rd_data),  32'hA1);
    chk("stamp_a_stamp", 32'(rd_stamp), 32'(STAMP_A));
    state_in = 4'h0;
    repeat (6) step();
    state_in = 4'h4; acc_in = 8'hA2;
    step();
    state_in = 4'h0;
    chk("stamp_b_count", 32'(count),    32'd2);
    chk("stamp_b_head",  32'(rd_stamp), 32'(STAMP_A));
    rd_ready = 1'b1;
    step();
    chk("stamp_b_data",  32'(rd_data),  32'hA2);
    chk("stamp_b_stamp", 32'(rd_stamp), 32'(STAMP_B));
    step();
    chk("stamp_empty_valid", 32'(rd_valid), 32'd0);
    chk("stamp_empty_stamp", 32'(rd_stamp), 32'd0);
    chk("stamp_empty_data",  32'(rd_data),  32'd0);
    rd_ready = 1'b0;

    // Single capture 0->4->0, then pop
    state_in = 4'h4; acc_in = 8'h5A;
    step();
    state_in = 4'h0; acc_in = 8'h00;
    chk("t1_valid", 32'(rd_valid), 32'd1);
    chk("t1_data",  32'(rd_data),  32'h5A);
    chk("t1_count", 32'(count),    32'd1);
    rd_ready = 1'b1;
    step();
    chk("t1_pop_valid", 32'(rd_valid), 32'd0);
    chk("t1_pop_count", 32'(count),    32'd0);
    step();
    chk("t1_empty_pop_count", 32'(count), 32'd0);
    rd_ready = 1'b0;

    // STORE held for 3 cycles -> one entry
    state_in = 4'h4; acc_in = 8'h11;
    repeat (3) step();
    state_in = 4'h0;
    step();
    chk("t2_count", 32'(count),   32'd1);
    chk("t2_data",  32'(rd_data), 32'h11);
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    chk("t2_drain_count", 32'(count), 32'd0);

    // Nine captures into eight slots
    for (int i = 1; i <= 9; i++) capture(8'(i));
    chk("t3_full",     32'(full),     32'd1);
    chk("t3_count",    32'(count),    32'd8);
    chk("t3_overflow", 32'(overflow), 32'd1);
    rd_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("t3_drain%0d", i), 32'(rd_data), 32'(i));
      step();
    end
    rd_ready = 1'b0;
    chk("t3_end_valid",    32'(rd_valid), 32'd0);
    chk("t3_end_count",    32'(count),    32'd0);
    chk("t3_end_overflow", 32'(overflow), 32'd1);

    // Full with simultaneous pop and capture
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("t4_clr_overflow", 32'(overflow), 32'd0);
    for (int i = 1; i <= 8; i++) capture(8'(8'h20 + i));
    chk("t4_full", 32'(full), 32'd1);
    state_in = 4'h4; acc_in = 8'hEE; rd_ready = 1'b1;
    step();
    state_in = 4'h0;
    chk("t4_count",    32'(count),    32'd8);
    chk("t4_full2",    32'(full),     32'd1);
    chk("t4_overflow", 32'(overflow), 32'd0);
    for (int i = 2; i <= 8; i++) begin
      chk($sformatf("t4_drain%0d", i), 32'(rd_data), 32'(8'h20 + i));
      step();
    end
    chk("t4_last",  32'(rd_data), 32'hEE);
    step();
    rd_ready = 1'b0;
    chk("t4_end_count", 32'(count), 32'd0);

    // clr coincident with capture, then ena=0
    capture(8'h31); capture(8'h32); capture(8'h33);
    chk("t5_count3", 32'(count), 32'd3);
    state_in = 4'h4; acc_in = 8'h44; clr = 1'b1;
    step();
    clr = 1'b0; state_in = 4'h0;
    chk("t5_count",    32'(count),    32'd0);
    chk("t5_valid",    32'(rd_valid), 32'd0);
    chk("t5_overflow", 32'(overflow), 32'd0);
    chk("t5_data",     32'(rd_data),  32'd0);
    step();
    chk("t5_after_count", 32'(count), 32'd0);
    ena = 1'b0;
    capture(8'h55);
    chk("t5_ena0_count", 32'(count),    32'd0);
    chk("t5_ena0_valid", 32'(rd_valid), 32'd0);
    ena = 1'b1;
    capture(8'h66);
    chk("t5_ena1_data", 32'(rd_data), 32'h66);

    // Asynchronous reset mid-operation
    capture(8'h77);
    chk("t6_count2", 32'(count), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("t6_async_count", 32'(count),    32'd0);
    chk("t6_async_valid", 32'(rd_valid), 32'd0);
    chk("t6_async_data",  32'(rd_data),  32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("t6_post_count", 32'(count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/minirisc_store_fifo.md
Name: minirisc_store_fifo

Overview:
- Downstream capture stage for the minirisc accumulator core.
- Watches the core's accumulator bus and state nibble. Each time the core enters its STORE state (state code 4'h4), the accumulator value is pushed into a small FIFO.
- A host or test harness drains the FIFO through a first-word-fall-through valid/ready port.
- Provides occupancy, full/empty and a sticky overflow flag.

Parameters:
- DEPTH, 8, number of FIFO entries; must be a power of two, minimum 2.
- ADDR_W, 3, pointer width; must equal log2(DEPTH).
- STORE_CODE, 4'h4, state code that triggers a capture.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- ena  input  1  capture enable; mirrors the core's ena
- acc_in  input  8  core accumulator value
- state_in  input  4  core state nibble
- clr  input  1  synchronous flush
- rd_data  output  8  head entry, valid when rd_valid=1
- rd_stamp  output  8  head entry timestamp (see Optional Feature)
- rd_valid  output  1  FIFO non-empty
- rd_ready  input  1  consumer accepts head entry
- count  output  ADDR_W+1  current occupancy, 0..DEPTH
- full  output  1  count==DEPTH
- overflow  output  1  sticky: a capture was dropped

Behaviour:
- Reset values (async, rst_n=0): rd_ptr=0, wr_ptr=0, count=0, overflow=0, prev_state=0, stamp counter=0. Outputs: rd_valid=0, full=0, count=0, overflow=0, rd_data=0, rd_stamp=0. Memory contents are don't-care but must not be visible while rd_valid=0.
- rd_data and rd_stamp are forced to 0 when empty.
- prev_state register: loads state_in every cycle.
- capture event, cap = ena && state_in==STORE_CODE && prev_state!=STORE_CODE. This is entry-edge detection. A STORE held for N cycles yields exactly one capture. Back-to-back STOREs separated by at least one non-STORE cycle each capture.
- acc_in is sampled on the same edge where cap=1.
- pop = rd_valid && rd_ready. Head advances on that edge.
- push = cap && (!full || pop). When full, a simultaneous pop frees the slot: push succeeds and count is unchanged.
- cap && full && !pop: data dropped, overflow<=1, pointers and count unchanged.
- Latency: a capture on edge k gives rd_valid=1 and rd_data=captured value after edge k, i.e. visible in cycle k+1. FIFO order is strict.
- Empty with rd_ready=1: no effect. Pointers never move on an invalid pop.
- Pointers are ADDR_W bits and wrap modulo DEPTH. count is tracked explicitly: +1 on push only, -1 on pop only, unchanged on both or neither.
- clr=1: on that edge count, rd_ptr and wr_ptr go to 0 and overflow goes to 0. clr overrides push and pop in the same cycle; a coincident capture is discarded and does not set overflow. prev_state still updates.
- ena=0: no captures. Pops continue normally. Contents are retained.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). Stored data is lost.
- No combinational path from rd_ready to rd_valid, count or full.

Optional Feature:
- Macro: MINIRISC_STORE_STAMP_EN.
- Defined:
  - An 8-bit free-running cycle counter runs. It increments every clk while ena=1, wraps 255->0, resets to 0, and is cleared by clr.
  - Each push also stores the counter value sampled on the capture edge, in a parallel array.
  - rd_stamp presents the head entry's stamp; it is 0 when empty.
- Not defined:
  - No counter and no stamp array are instantiated.
  - rd_stamp is tied to 8'h00.
  - All other behaviour is identical.

Test Plan:
- Reset, then sequence state_in 0->4->0 with acc_in=8'h5A at the STORE cycle -> one cycle later rd_valid=1, rd_data=8'h5A, count=1. Pulse rd_ready -> rd_valid=0, count=0.
- Hold state_in=4 for 3 cycles with acc_in=8'h11 -> exactly one entry, count=1.
- Perform 9 separate STORE entries (acc 1..9) with DEPTH=8 and rd_ready=0 -> full=1, count=8, overflow=1. Drain yields 1..8 in order; 9 is lost.
- Hold FIFO full, then capture acc=8'hEE with rd_ready=1 in the same cycle -> count stays 8, overflow stays 0, last drained entry is 8'hEE.
- Fill with 3 entries, then assert clr coincident with a capture -> count=0, rd_valid=0, overflow=0, new value not stored. With ena=0 a STORE entry produces no capture.
- With MINIRISC_STORE_STAMP_EN: captures on cycles 5 and 12 after reset release (ena=1) -> rd_stamp reads 5 then 12. Without the macro, rd_stamp=0 throughout.
